// File: rtl/pn_pkg.sv
// pn_pkg: shared definitions for the Polish-notation stack evaluator.
//   - opcode values carried in the token payload when in_op=1
//   - error codes reported on out_err
//   - FSM state encoding
package pn_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;  // a + b
  localparam logic [2:0] OP_SUB = 3'd1;  // a - b
  localparam logic [2:0] OP_MUL = 3'd2;  // a * b, low bits
  localparam logic [2:0] OP_ABS = 3'd3;  // |a + b|
  localparam logic [2:0] OP_MIN = 3'd4;  // signed min
  localparam logic [2:0] OP_MAX = 3'd5;  // signed max

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_UNDER = 3'd1;  // operator with fewer than 2 entries
  localparam logic [2:0] ERR_SOVF  = 3'd2;  // push onto a full stack
  localparam logic [2:0] ERR_TOVF  = 3'd3;  // more tokens than the buffer holds
  localparam logic [2:0] ERR_MALF  = 3'd4;  // final depth != 1
  localparam logic [2:0] ERR_ILLOP = 3'd5;  // opcode 6/7

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    EVAL = 2'd2,
    OUT  = 2'd3
  } state_e;

endpackage

// File: rtl/pn_alu.sv
// pn_alu: combinational arithmetic for one evaluator step.
//   a_i, b_i  : signed operands (DATA_W)
//   op_i      : opcode (OP_W bits, OP_ADD..OP_MAX legal)
//   res_o     : a op b, wrapping modulo 2^DATA_W
//   illegal_o : opcode outside the legal set
module pn_alu
  import pn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic        [OP_W-1:0]   op_i,
  output logic signed [DATA_W-1:0] res_o,
  output logic                     illegal_o
);

  logic signed [DATA_W-1:0] sum;

  always_comb begin
    sum       = a_i + b_i;
    res_o     = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_W'(OP_ADD): res_o = sum;
      OP_W'(OP_SUB): res_o = a_i - b_i;
      OP_W'(OP_MUL): res_o = a_i * b_i;
      // negating the most negative sum wraps back to itself
      OP_W'(OP_ABS): res_o = sum[DATA_W-1] ? -sum : sum;
      OP_W'(OP_MIN): res_o = (a_i < b_i) ? a_i : b_i;
      OP_W'(OP_MAX): res_o = (a_i < b_i) ? b_i : a_i;
      default:       illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pn_stack_eval.sv
// pn_stack_eval: buffers one Polish-notation expression, then evaluates it
// on a stack at one token per cycle, in postfix or prefix order.
//   clk, rst              : clock, async active-high reset
//   mode                  : 0 postfix, 1 prefix (sampled on first token)
//   in_valid/in_ready     : token handshake
//   in_op, in_data        : operator flag and operand value / opcode
//   in_last               : final token of the expression
//   out_valid/out_ready   : result handshake
//   out_data, out_err     : signed result (0 on error) and error code
module pn_stack_eval
  import pn_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TOK_W       = 3,
  parameter int MAX_TOK     = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_op,
  input  logic [TOK_W-1:0]  in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_err
);

  localparam int CW  = $clog2(MAX_TOK + 1);
  localparam int IW  = $clog2(MAX_TOK);
  localparam int SW  = $clog2(STACK_DEPTH + 1);
  localparam int SIW = $clog2(STACK_DEPTH);
  localparam logic [CW-1:0] MAX_TOK_C = CW'(MAX_TOK);
  localparam logic [SW-1:0] DEPTH_C   = SW'(STACK_DEPTH);

  state_e            state_q;
  logic              mode_q;
  logic              tok_ovf_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     scan_q;
  logic [SW-1:0]     sp_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [2:0]        out_err_q;

  // storage without reset: contents are only read below the valid count/sp
  logic [MAX_TOK-1:0]                  buf_op_q;
  logic [MAX_TOK-1:0][TOK_W-1:0]       buf_data_q;
  logic [STACK_DEPTH-1:0][DATA_W-1:0]  stk_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

  // ---------------- token capture ----------------
  logic          tok_acc;
  logic          buf_we;
  logic [IW-1:0] buf_widx;

  // in_ready_q is only high in IDLE/RECV, so it fully qualifies acceptance
  assign tok_acc  = in_valid && in_ready_q;
  assign buf_we   = tok_acc && ((state_q == IDLE) || (cnt_q < MAX_TOK_C));
  assign buf_widx = (state_q == IDLE) ? '0 : cnt_q[IW-1:0];

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_op_q[buf_widx]   <= in_op;
      buf_data_q[buf_widx] <= in_data;
    end
  end

  // ---------------- evaluation datapath ----------------
  logic [IW-1:0]     tok_pos;
  logic              cur_op;
  logic [TOK_W-1:0]  cur_data;
  logic [SIW-1:0]    top_idx, nxt_idx;
  logic [DATA_W-1:0] top_w, nxt_w, alu_a, alu_b, alu_res, opnd;
  logic              alu_ill;
  logic              ev_run, do_push, do_op;
  logic [2:0]        ev_err;

  // prefix walks the buffer backwards from the last token
  assign tok_pos  = IW'(mode_q ? (cnt_q - scan_q - CW'(1)) : scan_q);
  assign cur_op   = buf_op_q[tok_pos];
  assign cur_data = buf_data_q[tok_pos];
  assign opnd     = DATA_W'(cur_data);

  assign top_idx = SIW'(sp_q - SW'(1));
  assign nxt_idx = SIW'(sp_q - SW'(2));
  assign top_w   = stk_q[top_idx];
  assign nxt_w   = stk_q[nxt_idx];
  // postfix: b is on top; prefix: a is on top
  assign alu_a   = mode_q ? top_w : nxt_w;
  assign alu_b   = mode_q ? nxt_w : top_w;

  pn_alu #(.DATA_W(DATA_W), .OP_W(TOK_W)) u_alu (
    .a_i       (alu_a),
    .b_i       (alu_b),
    .op_i      (cur_data),
    .res_o     (alu_res),
    .illegal_o (alu_ill)
  );

  assign ev_run = (state_q == EVAL) && !tok_ovf_q && (scan_q != cnt_q);

  always_comb begin
    ev_err = ERR_NONE;
    if (ev_run) begin
      if (!cur_op) begin
        if (sp_q == DEPTH_C) ev_err = ERR_SOVF;
      end else if (sp_q < SW'(2)) begin
        ev_err = ERR_UNDER;
      end else if (alu_ill) begin
        ev_err = ERR_ILLOP;
      end
    end
  end

  assign do_push = ev_run && !cur_op && (ev_err == ERR_NONE);
  assign do_op   = ev_run &&  cur_op && (ev_err == ERR_NONE);

  always_ff @(posedge clk) begin
    if (do_push)    stk_q[sp_q[SIW-1:0]] <= opnd;
    else if (do_op) stk_q[nxt_idx]       <= alu_res;
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      tok_ovf_q   <= 1'b0;
      cnt_q       <= '0;
      scan_q      <= '0;
      sp_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= ERR_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (tok_acc) begin
            mode_q    <= mode;
            cnt_q     <= CW'(1);
            scan_q    <= '0;
            sp_q      <= '0;
            tok_ovf_q <= 1'b0;
            if (in_last) begin
              state_q    <= EVAL;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= RECV;
            end
          end
        end
        RECV: begin
          if (tok_acc) begin
            // overflowing tokens are dropped but framing is still honoured
            if (cnt_q == MAX_TOK_C) tok_ovf_q <= 1'b1;
            else                    cnt_q     <= cnt_q + CW'(1);
            if (in_last) begin
              state_q    <= EVAL;
              in_ready_q <= 1'b0;
            end
          end
        end
        EVAL: begin
          if (tok_ovf_q) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            out_data_q  <= '0;
            out_err_q   <= ERR_TOVF;
          end else if (scan_q == cnt_q) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            if (sp_q == SW'(1)) begin
              out_data_q <= stk_q[0];
              out_err_q  <= ERR_NONE;
            end else begin
              out_data_q <= '0;
              out_err_q  <= ERR_MALF;
            end
          end else if (ev_err != ERR_NONE) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            out_data_q  <= '0;
            out_err_q   <= ev_err;
          end else begin
            scan_q <= scan_q + CW'(1);
            sp_q   <= do_push ? sp_q + SW'(1) : sp_q - SW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
            scan_q      <= '0;
            sp_q        <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pn_stack_eval.sv
module tb_pn_stack_eval;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance: DATA_W=32, MAX_TOK=16, STACK_DEPTH=8
  logic        mode, in_valid, in_ready, in_op, in_last, out_valid, out_ready;
  logic [2:0]  in_data, out_err;
  logic [31:0] out_data;

  // 8-bit instance for wrap-around
  logic       m8_valid, m8_ready, m8_op, m8_last, o8_valid, o8_ready;
  logic [2:0] m8_data, o8_err;
  logic [7:0] o8_data;

  int checks = 0;
  int errors = 0;

  bit         t_op  [40];
  logic [2:0] t_dat [40];

  pn_stack_eval dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  pn_stack_eval #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .mode(1'b0), .in_valid(m8_valid), .in_ready(m8_ready),
    .in_op(m8_op), .in_data(m8_data), .in_last(m8_last), .out_valid(o8_valid),
    .out_ready(o8_ready), .out_data(o8_data), .out_err(o8_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tk(input int i, input bit op, input logic [2:0] d);
    t_op[i]  = op;
    t_dat[i] = d;
  endtask

  task automatic push_tok(input bit op, input logic [2:0] d, input bit last);
    bit got;
    got = 0;
    in_valid = 1'b1; in_op = op; in_data = d; in_last = last;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk); #1;
        got = 1;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL push_tok in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic send_expr(input int n, input bit md);
    mode = md;
    for (int i = 0; i < n; i++) push_tok(t_op[i], t_dat[i], i == n - 1);
  endtask

  task automatic wait_result(output logic [31:0] d, output logic [2:0] e, output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    d = out_data;
    e = out_err;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL wait_result out_valid never rose");
    end
  endtask

  task automatic hs();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_expr(input int n, input bit md, output logic [31:0] d,
                          output logic [2:0] e, output int lat);
    send_expr(n, md);
    wait_result(d, e, lat);
    hs();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_err !== 3'd0) begin errors++; $display("FAIL reset_out_err got %0d want 0", out_err); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_postfix_basic();
    logic [31:0] d; logic [2:0] e; int lat;
    // 3 4 + 2 *
    tk(0,0,3); tk(1,0,4); tk(2,1,0); tk(3,0,2); tk(4,1,2);
    run_expr(5, 0, d, e, lat);
    checks++; if (d !== 32'd14) begin errors++; $display("FAIL postfix_basic data got %0d want 14", d); end
    checks++; if (e !== 3'd0) begin errors++; $display("FAIL postfix_basic err got %0d want 0", e); end
    checks++; if (lat != 6) begin errors++; $display("FAIL postfix_basic latency got %0d want 6", lat); end
  endtask

  task automatic test_ops();
    logic [31:0] d; logic [2:0] e; int lat;
    // prefix - 5 * 2 3 = 5 - 6
    tk(0,1,1); tk(1,0,5); tk(2,1,2); tk(3,0,2); tk(4,0,3);
    run_expr(5, 1, d, e, lat);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL prefix_sub data got %h want ffffffff", d); end
    checks++; if (e !== 3'd0) begin errors++; $display("FAIL prefix_sub err got %0d want 0", e); end
    // postfix 1 7 -
    tk(0,0,1); tk(1,0,7); tk(2,1,1);
    run_expr(3, 0, d, e, lat);
    checks++; if (d !== 32'hFFFF_FFFA) begin errors++; $display("FAIL postfix_sub data got %h want fffffffa", d); end
    // postfix 1 7 min 4 max
    tk(0,0,1); tk(1,0,7); tk(2,1,4); tk(3,0,4); tk(4,1,5);
    run_expr(5, 0, d, e, lat);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL min_max data got %0d want 4", d); end
    // postfix 2 7 - 0 abs  -> |-5 + 0|
    tk(0,0,2); tk(1,0,7); tk(2,1,1); tk(3,0,0); tk(4,1,3);
    run_expr(5, 0, d, e, lat);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL abs data got %0d want 5", d); end
    // single operand
    tk(0,0,6);
    run_expr(1, 0, d, e, lat);
    checks++; if (d !== 32'd6 || e !== 3'd0) begin errors++; $display("FAIL single_operand data %0d err %0d want 6/0", d, e); end
  endtask

  task automatic test_wrap8();
    logic [4:0]  opv;
    logic [14:0] dv;
    int lat;
    bit rdy_ok;
    // 7 7 * 7 *
    opv = 5'b10100;
    dv  = {3'd2, 3'd7, 3'd2, 3'd7, 3'd7};
    rdy_ok = 1;
    for (int i = 0; i < 5; i++) begin
      m8_valid = 1'b1; m8_op = opv[i]; m8_data = dv[3*i +: 3]; m8_last = (i == 4);
      @(negedge clk);
      if (m8_ready !== 1'b1) rdy_ok = 0;
      @(posedge clk); #1;
    end
    m8_valid = 1'b0; m8_last = 1'b0;
    checks++; if (!rdy_ok) begin errors++; $display("FAIL wrap8_ready got 0 want 1"); end
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if (o8_valid === 1'b1) begin lat = k; break; end
    end
    checks++; if (o8_data !== 8'h57) begin errors++; $display("FAIL wrap8 data got %h want 57 (lat %0d)", o8_data, lat); end
    checks++; if (o8_err !== 3'd0) begin errors++; $display("FAIL wrap8 err got %0d want 0", o8_err); end
    o8_ready = 1'b1; @(posedge clk); #1; o8_ready = 1'b0;
  endtask

  task automatic test_errors();
    logic [31:0] d; logic [2:0] e; int lat;
    bit rdy_ok;
    // 3 +
    tk(0,0,3); tk(1,1,0);
    run_expr(2, 0, d, e, lat);
    checks++; if (e !== 3'd1 || d !== 32'd0) begin errors++; $display("FAIL underflow err %0d data %0d want 1/0", e, d); end
    // lone operator
    tk(0,1,0);
    run_expr(1, 0, d, e, lat);
    checks++; if (e !== 3'd1) begin errors++; $display("FAIL lone_op err got %0d want 1", e); end
    // 1 2 3 +
    tk(0,0,1); tk(1,0,2); tk(2,0,3); tk(3,1,0);
    run_expr(4, 0, d, e, lat);
    checks++; if (e !== 3'd4 || d !== 32'd0) begin errors++; $display("FAIL malformed err %0d data %0d want 4/0", e, d); end
    // 1 2 op6
    tk(0,0,1); tk(1,0,2); tk(2,1,6);
    run_expr(3, 0, d, e, lat);
    checks++; if (e !== 3'd5 || d !== 32'd0) begin errors++; $display("FAIL illop err %0d data %0d want 5/0", e, d); end
    // nine operands into an 8-deep stack
    for (int i = 0; i < 9; i++) tk(i, 0, 3'(i));
    run_expr(9, 0, d, e, lat);
    checks++; if (e !== 3'd2 || d !== 32'd0) begin errors++; $display("FAIL stack_ovf err %0d data %0d want 2/0", e, d); end
    // 17 tokens into a 16-entry buffer; ready must hold until last
    mode = 1'b0;
    rdy_ok = 1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_op = 1'b0; in_data = 3'd1; in_last = (i == 16);
      @(negedge clk);
      if (in_ready !== 1'b1) rdy_ok = 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (!rdy_ok) begin errors++; $display("FAIL tok_ovf_ready dropped before last, want 1"); end
    wait_result(d, e, lat);
    hs();
    checks++; if (e !== 3'd3 || d !== 32'd0) begin errors++; $display("FAIL tok_ovf err %0d data %0d want 3/0", e, d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [2:0] e; int lat;
    tk(0,0,2); tk(1,0,3); tk(2,1,0);
    send_expr(3, 0);
    // a competing token held high during EVAL and OUT must be ignored
    in_valid = 1'b1; in_op = 1'b0; in_data = 3'd6; in_last = 1'b1;
    wait_result(d, e, lat);
    checks++; if (d !== 32'd5 || lat != 4) begin errors++; $display("FAIL bp_first data %0d lat %0d want 5/4", d, lat); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd5 || out_err !== 3'd0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc %0d valid %b data %0d err %0d ready %b want 1/5/0/0",
                 c, out_valid, out_data, out_err, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_handshake valid %b ready %b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;   // held token accepted here, in IDLE
    in_valid = 1'b0; in_last = 1'b0;
    wait_result(d, e, lat);
    hs();
    checks++; if (d !== 32'd6 || lat != 2) begin errors++; $display("FAIL bp_second data %0d lat %0d want 6/2", d, lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [2:0] e; int lat;
    bit stray;
    tk(0,0,1); tk(1,0,2); tk(2,0,3); tk(3,1,0); tk(4,1,0);
    send_expr(5, 0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_err !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid valid %b ready %b err %0d want 0/1/0", out_valid, in_ready, out_err);
    end
    #1 rst = 1'b0;
    stray = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stray = 1;
    end
    checks++; if (stray) begin errors++; $display("FAIL reset_mid_stray out_valid 1 want 0"); end
    tk(0,0,2); tk(1,0,3); tk(2,1,0);
    run_expr(3, 0, d, e, lat);
    checks++; if (d !== 32'd5 || e !== 3'd0) begin errors++; $display("FAIL after_reset data %0d err %0d want 5/0", d, e); end
  endtask

  initial begin
    mode = 0; in_valid = 0; in_op = 0; in_data = 0; in_last = 0; out_ready = 0;
    m8_valid = 0; m8_op = 0; m8_data = 0; m8_last = 0; o8_ready = 0;
    test_reset();
    test_postfix_basic();
    test_ops();
    test_wrap8();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pn_stack_eval.md
Name: pn_stack_eval

Overview:
Parametrised stack-based Polish-notation evaluator. Accepts one expression as a token stream with valid/ready and last-token framing. Evaluates it in either prefix or postfix order, at one token per cycle. Returns one signed result with an error code through a valid/ready output; it is the generalised successor of the fixed 12-token, 4-op evaluator.

Parameters:
DATA_W, 32, result/stack word width (signed, two's complement)
TOK_W, 3, token payload width (operand value or opcode)
MAX_TOK, 16, token buffer depth (max tokens per expression)
STACK_DEPTH, 8, evaluation stack entries

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
mode  in  1  0=postfix, 1=prefix; sampled on first accepted token
in_valid  in  1  token valid
in_ready  out  1  block can accept token
in_op  in  1  1=token is operator, 0=operand
in_data  in  TOK_W  operand value (zero-extended) or opcode
in_last  in  1  final token of expression
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  DATA_W  signed result (0 on error)
out_err  out  3  0 ok, 1 underflow, 2 stack overflow, 3 token overflow, 4 malformed (final depth != 1), 5 illegal opcode

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; out_data=0; out_err=0; counters and stack pointer 0.
- States:
  - IDLE: in_ready=1. On in_valid, latch mode, store token 0, count=1. Go to RECV, or to EVAL if in_last.
  - RECV: in_ready=1. Store each accepted token. On in_last, go to EVAL.
  - RECV token overflow: a token accepted when count==MAX_TOK is discarded and sticky tok_ovf is set. Keep accepting until in_last.
  - EVAL: in_ready=0. Entering EVAL with tok_ovf set goes straight to OUT with err 3.
  - EVAL order: process one buffered token per cycle. Postfix scans index 0..count-1; prefix scans count-1..0.
  - OUT: out_valid=1, out_data/out_err stable until out_ready. On the handshake cycle, clear out_valid and return to IDLE.
- Evaluation rules:
  - Operand: push zero-extended value. If sp==STACK_DEPTH, raise err 2.
  - Operator with sp<2: err 1.
  - Postfix pops b=top, a=next. Prefix pops a=top, b=next. Push a op b.
- Opcodes: 0 a+b, 1 a-b, 2 a*b (low DATA_W bits), 3 |a+b|, 4 min(a,b), 5 max(a,b) signed; 6/7 raise err 5.
- All arithmetic wraps modulo 2^DATA_W. No saturation.
- Errors abort EVAL immediately: next state OUT, out_data=0. First error wins.
- End of scan: sp==1 gives out_data=stack[0], err 0; otherwise err 4.
- Latency: with N tokens buffered and no error, out_valid rises N+1 cycles after the in_last handshake edge.
- Backpressure: only one expression in flight. in_ready stays 0 from EVAL until the OUT handshake. in_valid during EVAL/OUT is ignored.
- Simultaneous out handshake and in_valid: the token is not accepted that cycle; it is accepted next cycle in IDLE.
- Single-token expression: an operand alone returns that value; an operator alone gives err 1.

Decomposition:
- Shared package pn_pkg holds:
  - opcode localparams OP_ADD..OP_MAX
  - error-code localparams ERR_NONE..ERR_ILLOP
  - state encoding IDLE/RECV/EVAL/OUT
- One combinational sub-module pn_alu (DATA_W param) takes a, b and opcode, and returns the result and an illegal flag.
- Token buffer, stack, FSM and handshake stay in pn_stack_eval.

Test Plan:
- Postfix 3 4 + 2 * with in_last on *: out_data=14, out_err=0, out_valid exactly 6 cycles after the last handshake.
- Prefix - 5 * 2 3: out_data=-1 (0xFFFFFFFF), err 0. Then postfix 1 7 -: -6. Then postfix 1 7 min 4 max (op codes 4, 5): 4.
- DATA_W=8, postfix 7 7 * 7 *: 343 mod 256, giving out_data=87 (0x57), err 0.
- Errors: postfix 3 + gives err 1, data 0. Postfix 1 2 3 + gives err 4. Opcode 6 gives err 5. 17 tokens with MAX_TOK=16 gives err 3, and in_ready stays 1 until in_last. STACK_DEPTH+1 operands gives err 2.
- Backpressure: hold out_ready=0 for 5 cycles. out_valid/out_data stay constant and in_ready=0; the next expression is accepted only after the handshake.
- Reset mid-EVAL (rst pulse): out_valid=0, in_ready=1 immediately. The following expression 2 3 + evaluates to 5.
